// File: rtl/mram_burst_sched_if.sv
// Beat-address bus between the burst scheduler and the MRAM address serialiser.
// The scheduler drives addresses and the serialiser returns back-pressure through mem_ready.
interface mram_burst_sched_if #(
  parameter int ADDR_W = 16
);
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic              mem_last;

  modport master (
    output mem_valid,
    output mem_addr,
    output mem_last,
    input  mem_ready
  );

  modport slave (
    input  mem_valid,
    input  mem_addr,
    input  mem_last,
    output mem_ready
  );
endinterface

// File: rtl/mram_burst_sched.sv
// Round-robin scheduler that shares one MRAM burst datapath between two requesters.
// It latches the winner's address, mode and length, then issues one beat address per accepted handshake.
module mram_burst_sched #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        req_mode,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [LEN_W-1:0]  req_len0,
  input  logic [LEN_W-1:0]  req_len1,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic              done,
  output logic              done_id,
  mram_burst_sched_if.master mem
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_ISSUE,
    ST_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic              last_id;
  logic              winner;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  beats_left;

  logic              pick;
  logic              sel_mode;
  logic [LEN_W-1:0]  sel_len;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  start_beats;
  logic              last_beat;
  logic              beat_accept;

  // A lone requester wins outright; on a tie the one not served last wins.
  always_comb begin
    if (req == 2'b11) pick = ~last_id;
    else              pick = req[1];
  end

  assign sel_mode = pick ? req_mode[1] : req_mode[0];
  assign sel_len  = pick ? req_len1    : req_len0;
  assign sel_addr = pick ? req_addr1   : req_addr0;

  // Single transfers and zero-length bursts both collapse to one beat.
  assign start_beats = (sel_mode && (sel_len != '0)) ? sel_len : LEN_W'(1);

  assign last_beat   = (beats_left == LEN_W'(1));
  assign beat_accept = (state == ST_ISSUE) && mem.mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req != 2'b00) state_nxt = ST_GRANT;
      ST_GRANT: state_nxt = ST_ISSUE;
      ST_ISSUE: if (beat_accept && last_beat) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_id    <= 1'b1;
      winner     <= 1'b0;
      cur_addr   <= '0;
      beats_left <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req != 2'b00) begin
            winner     <= pick;
            cur_addr   <= sel_addr;
            beats_left <= start_beats;
          end
        end
        ST_ISSUE: begin
          if (mem.mem_ready) begin
            cur_addr   <= cur_addr + 1'b1;
            beats_left <= beats_left - 1'b1;
          end
        end
        ST_DONE: last_id <= winner;
        default: ;
      endcase
    end
  end

  // Outputs decode only from state and registers, never from req or mem_ready.
  always_comb begin
    gnt           = 2'b00;
    busy          = 1'b0;
    done          = 1'b0;
    done_id       = 1'b0;
    mem.mem_valid = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_last  = 1'b0;
    case (state)
      ST_GRANT: begin
        busy        = 1'b1;
        gnt[winner] = 1'b1;
      end
      ST_ISSUE: begin
        busy          = 1'b1;
        mem.mem_valid = 1'b1;
        mem.mem_addr  = cur_addr;
        mem.mem_last  = last_beat;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        done_id = winner;
      end
      default: ;
    endcase
  end

endmodule
